// File: rtl/onehot_walker.sv
// -----------------------------------------------------------------------------
// onehot_walker
//   Moves a single set bit along a WIDTH-bit register when a push-button is
//   pressed. The bit can move toward the MSB or toward the LSB. Holding the
//   button auto-repeats the step every TICK_DIV cycles. At either end the bit
//   either wraps to the opposite end or saturates. A binary index of the set
//   bit is registered alongside the one-hot value, so it never goes through a
//   priority encoder.
//
// Parameters
//   WIDTH     width of the one-hot position register (>= 2)
//   TICK_DIV  clk cycles between auto-repeat steps while btn is held (>= 2)
//   ENC_W     width of the binary index, $clog2(WIDTH)
//
// Ports
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   btn         raw push-button level, asynchronous to clk
//   dir         0 = step toward MSB, 1 = step toward LSB
//   wrap_en     1 = wrap at the ends, 0 = saturate at the ends
//   load        synchronous load of load_pos; has priority over stepping
//   load_pos    index to load; values >= WIDTH are ignored
//   pos         one-hot position, exactly one bit set
//   idx         binary index of the set bit in pos
//   at_end      pos sits at the end that the next step in dir would reach
//   step_pulse  one-cycle pulse on every cycle in which pos takes a step
// -----------------------------------------------------------------------------
module onehot_walker #(
  parameter  int WIDTH    = 16,
  parameter  int TICK_DIV = 100_000_000,
  localparam int ENC_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [ENC_W-1:0] load_pos,
  output logic [WIDTH-1:0] pos,
  output logic [ENC_W-1:0] idx,
  output logic             at_end,
  output logic             step_pulse
);

  localparam logic [WIDTH-1:0] POS_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] POS_MSB = POS_LSB << (WIDTH - 1);
  localparam logic [ENC_W-1:0] IDX_MAX = ENC_W'(WIDTH - 1);
  localparam logic [31:0]      CNT_MAX = 32'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Button synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic btn_meta;
  logic btn_sync;
  logic btn_prev;
  logic rise;

  // NOTE: every clocked process uses non-blocking assignments, so all
  // registers sample their inputs as they were just before the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign rise = btn_sync & ~btn_prev;

  // ---------------------------------------------------------------------------
  // Auto-repeat prescaler. It restarts on every rise, so the first repeat
  // comes TICK_DIV cycles after the step taken for the press itself.
  // ---------------------------------------------------------------------------
  logic [31:0] cnt;
  logic        rpt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (rise || !btn_sync || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  assign rpt = btn_sync & ~rise & (cnt == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Position / index next-state
  // ---------------------------------------------------------------------------
  logic             step_req;
  logic [WIDTH-1:0] pos_nxt;
  logic [ENC_W-1:0] idx_nxt;
  logic             pulse_nxt;

  assign step_req = rise | rpt;
  assign at_end   = dir ? pos[0] : pos[WIDTH-1];

  // NOTE: each signal gets a default before any branch, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pos_nxt   = pos;
    idx_nxt   = idx;
    pulse_nxt = 1'b0;
    if (load) begin
      // An out-of-range load changes nothing but still swallows the step.
      if (32'(load_pos) < WIDTH) begin
        pos_nxt = POS_LSB << load_pos;
        idx_nxt = load_pos;
      end
    end else if (step_req) begin
      if (!at_end) begin
        pulse_nxt = 1'b1;
        if (dir) begin
          pos_nxt = pos >> 1;
          idx_nxt = idx - ENC_W'(1);
        end else begin
          pos_nxt = pos << 1;
          idx_nxt = idx + ENC_W'(1);
        end
      end else if (wrap_en) begin
        pulse_nxt = 1'b1;
        if (dir) begin
          pos_nxt = POS_MSB;
          idx_nxt = IDX_MAX;
        end else begin
          pos_nxt = POS_LSB;
          idx_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pos        <= POS_LSB;
      idx        <= '0;
      step_pulse <= 1'b0;
    end else begin
      pos        <= pos_nxt;
      idx        <= idx_nxt;
      step_pulse <= pulse_nxt;
    end
  end

endmodule
